// File: rtl/pe_dot_pipe_if.sv
// rtl/pe_dot_pipe_if.sv - beat/result bundle between vector feeder, PE and row packer
//
// Ports (as seen by the PE through the slave modport):
//   clr        in   synchronous abort/flush, active high
//   in_valid   in   beat present on M/X
//   in_last    in   producer's end-of-vector marker (checked against the beat counter)
//   M, X       in   WCOUNT packed 4-bit matrix/vector words, word i at [4i+3:4i]
//   out_valid  out  one-cycle result strobe
//   out_raw    out  full unsigned dot product, ACC_W bits
//   out_nib    out  out_raw[SHIFT+3:SHIFT]
//   err        out  sticky framing error
//   busy       out  work in flight
interface pe_dot_pipe_if #(
    parameter int WCOUNT = 4,
    parameter int NBEATS = 16
);
    localparam int ACC_W = 8 + $clog2(WCOUNT * NBEATS);

    logic                  clr;
    logic                  in_valid;
    logic                  in_last;
    logic [WCOUNT*4-1:0]   M;
    logic [WCOUNT*4-1:0]   X;
    logic                  out_valid;
    logic [ACC_W-1:0]      out_raw;
    logic [3:0]            out_nib;
    logic                  err;
    logic                  busy;

    modport master (
        output clr, in_valid, in_last, M, X,
        input  out_valid, out_raw, out_nib, err, busy
    );

    modport slave (
        input  clr, in_valid, in_last, M, X,
        output out_valid, out_raw, out_nib, err, busy
    );
endinterface

// File: rtl/pe_dot_pipe.sv
// rtl/pe_dot_pipe.sv - pipelined 4-bit multiply-accumulate PE for one matrix row
//
// Ports:
//   clk   in  clock, all logic on rising edge
//   rst   in  asynchronous active-high reset, clears every register
//   bus   pe_dot_pipe_if.slave: clr/in_valid/in_last/M/X in,
//         out_valid/out_raw/out_nib/err/busy out
//
// Pipeline: S1 products -> S2 beat sum -> S3 accumulator/result.
// A final beat sampled at edge k produces out_valid in the cycle after edge k+2.
module pe_dot_pipe #(
    parameter int WCOUNT = 4,
    parameter int NBEATS = 16,
    parameter int SHIFT  = 10
) (
    input  logic          clk,
    input  logic          rst,
    pe_dot_pipe_if.slave  bus
);
    localparam int ACC_W = 8 + $clog2(WCOUNT * NBEATS);
    localparam int CNT_W = $clog2(NBEATS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBEATS - 1);

    logic [CNT_W-1:0] bcnt;
    logic             at_end;

    logic [7:0]       prod [WCOUNT];
    logic             v1;
    logic             last1;

    logic [ACC_W-1:0] beat_sum;
    logic [ACC_W-1:0] beat_sum_d;
    logic             v2;
    logic             last2;

    logic [ACC_W-1:0] acc;

    // The counter, not in_last, defines vector boundaries.
    assign at_end = (bcnt == LAST_CNT);

    always_comb begin
        beat_sum_d = '0;
        for (int i = 0; i < WCOUNT; i++) begin
            beat_sum_d = beat_sum_d + ACC_W'(prod[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt          <= '0;
            v1            <= 1'b0;
            last1         <= 1'b0;
            for (int i = 0; i < WCOUNT; i++) begin
                prod[i] <= '0;
            end
            v2            <= 1'b0;
            last2         <= 1'b0;
            beat_sum      <= '0;
            acc           <= '0;
            bus.out_valid <= 1'b0;
            bus.out_raw   <= '0;
            bus.err       <= 1'b0;
        end else if (bus.clr) begin
            // Flush in-flight work; out_raw keeps the last delivered result.
            bcnt          <= '0;
            v1            <= 1'b0;
            last1         <= 1'b0;
            v2            <= 1'b0;
            last2         <= 1'b0;
            acc           <= '0;
            bus.out_valid <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            // S1: per-word products
            v1    <= bus.in_valid;
            last1 <= bus.in_valid & at_end;
            if (bus.in_valid) begin
                for (int i = 0; i < WCOUNT; i++) begin
                    prod[i] <= {4'b0, bus.M[4*i +: 4]} * {4'b0, bus.X[4*i +: 4]};
                end
                bcnt <= at_end ? '0 : bcnt + CNT_W'(1);
                if (bus.in_last != at_end) begin
                    bus.err <= 1'b1;
                end
            end

            // S2: beat sum
            v2    <= v1;
            last2 <= v1 & last1;
            if (v1) begin
                beat_sum <= beat_sum_d;
            end

            // S3: accumulate; closing the vector clears acc so the next
            // vector may start on the very next beat.
            bus.out_valid <= 1'b0;
            if (v2) begin
                if (last2) begin
                    bus.out_raw   <= acc + beat_sum;
                    bus.out_valid <= 1'b1;
                    acc           <= '0;
                end else begin
                    acc <= acc + beat_sum;
                end
            end
        end
    end

    assign bus.out_nib = bus.out_raw[SHIFT+3:SHIFT];
    assign bus.busy    = (bcnt != '0) | v1 | v2;
endmodule
